// File: rtl/ctrl_arb_pkg.sv
// Shared defaults and types for the command arbiter / response router slice.
package ctrl_arb_pkg;

  localparam int unsigned DefaultDataW    = 32;
  localparam int unsigned DefaultTagDepth = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FWD  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ctrl_cmd_arbiter_if.sv
// AXI-Stream style bundle used for every command and response stream of the arbiter.
interface ctrl_cmd_arbiter_if
  import ctrl_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/ctrl_tag_fifo.sv
// 1-bit-wide show-ahead FIFO holding the requester id of each forwarded command packet.
module ctrl_tag_fifo
  import ctrl_arb_pkg::*;
#(
  parameter int unsigned  DEPTH = DefaultTagDepth,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic            inner_clk,
  input  logic            rst,
  input  logic            push,
  input  logic            push_bit,
  input  logic            pop,
  output logic            head,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  logic [DEPTH-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge inner_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge inner_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_bit;
  end

endmodule

// File: rtl/ctrl_cmd_arbiter.sv
// Packet-granular round-robin merge of two command streams, with in-order routing of the
// handler's responses back to the requester that issued each command packet.
module ctrl_cmd_arbiter
  import ctrl_arb_pkg::*;
#(
  parameter int unsigned  DATA_W    = DefaultDataW,
  parameter int unsigned  TAG_DEPTH = DefaultTagDepth,
  localparam int unsigned CntW      = $clog2(TAG_DEPTH) + 1
) (
  input  logic                inner_clk,
  input  logic                rst,
  ctrl_cmd_arbiter_if.slave   s0,
  ctrl_cmd_arbiter_if.slave   s1,
  ctrl_cmd_arbiter_if.master  cmd,
  ctrl_cmd_arbiter_if.slave   resp,
  ctrl_cmd_arbiter_if.master  m0,
  ctrl_cmd_arbiter_if.master  m1,
  output logic [CntW-1:0]     outstanding
);

  arb_state_t        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              lw_q, lw_d;
  logic              tag_push, tag_pop;
  logic              tag_head, tag_full, tag_empty;
  logic [DATA_W-1:0] sel_tdata;
  logic              sel_tvalid, sel_tlast;

  ctrl_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .inner_clk (inner_clk),
    .rst       (rst),
    .push      (tag_push),
    .push_bit  (gnt_q),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (outstanding)
  );

  assign sel_tdata  = gnt_q ? s1.tdata  : s0.tdata;
  assign sel_tvalid = gnt_q ? s1.tvalid : s0.tvalid;
  assign sel_tlast  = gnt_q ? s1.tlast  : s0.tlast;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    lw_d       = lw_q;
    tag_push   = 1'b0;
    cmd.tdata  = '0;
    cmd.tvalid = 1'b0;
    cmd.tlast  = 1'b0;
    s0.tready  = 1'b0;
    s1.tready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Grant is decided here; the bubble cycle keeps tready off until FWD.
        if (!tag_full && (s0.tvalid || s1.tvalid)) begin
          gnt_d   = (s0.tvalid && s1.tvalid) ? ~lw_q : s1.tvalid;
          state_d = FWD;
        end
      end
      FWD: begin
        cmd.tdata  = sel_tdata;
        cmd.tvalid = sel_tvalid;
        cmd.tlast  = sel_tlast;
        s0.tready  = ~gnt_q & cmd.tready;
        s1.tready  = gnt_q & cmd.tready;
        if (sel_tvalid && cmd.tready && sel_tlast) begin
          tag_push = 1'b1;
          lw_d     = gnt_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge inner_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      lw_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      lw_q    <= lw_d;
    end
  end

  // Response words are held off entirely while no command is awaiting a reply.
  always_comb begin
    resp.tready = 1'b0;
    m0.tvalid   = 1'b0;
    m1.tvalid   = 1'b0;
    if (!tag_empty) begin
      if (tag_head) begin
        m1.tvalid   = resp.tvalid;
        resp.tready = m1.tready;
      end else begin
        m0.tvalid   = resp.tvalid;
        resp.tready = m0.tready;
      end
    end
  end

  assign tag_pop  = resp.tvalid & resp.tready & resp.tlast;
  assign m0.tdata = resp.tdata;
  assign m0.tlast = resp.tlast;
  assign m1.tdata = resp.tdata;
  assign m1.tlast = resp.tlast;

endmodule

// File: tb/tb_ctrl_cmd_arbiter.sv
// Randomized bench for ctrl_cmd_arbiter; command bit 31 carries the requester id so the
// scoreboard can attribute every merged packet without looking inside the DUT.
module tb_ctrl_cmd_arbiter;
  import ctrl_arb_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned TD = 4;
  localparam int unsigned CW = $clog2(TD) + 1;
  localparam logic [63:0] NONE = '1;

  logic          inner_clk = 1'b0;
  logic          rst       = 1'b1;
  logic [CW-1:0] outstanding;

  always #5 inner_clk = ~inner_clk;

  ctrl_cmd_arbiter_if #(.DATA_W(DW)) s0_if ();
  ctrl_cmd_arbiter_if #(.DATA_W(DW)) s1_if ();
  ctrl_cmd_arbiter_if #(.DATA_W(DW)) cmd_if ();
  ctrl_cmd_arbiter_if #(.DATA_W(DW)) resp_if ();
  ctrl_cmd_arbiter_if #(.DATA_W(DW)) m0_if ();
  ctrl_cmd_arbiter_if #(.DATA_W(DW)) m1_if ();

  ctrl_cmd_arbiter #(
    .DATA_W    (DW),
    .TAG_DEPTH (TD)
  ) dut (
    .inner_clk   (inner_clk),
    .rst         (rst),
    .s0          (s0_if),
    .s1          (s1_if),
    .cmd         (cmd_if),
    .resp        (resp_if),
    .m0          (m0_if),
    .m1          (m1_if),
    .outstanding (outstanding)
  );

  int checks   = 0;
  int failures = 0;

  logic [32:0] src0_q[$], src1_q[$], exp0_q[$], exp1_q[$];
  logic [32:0] resp_q[$], want_m0_q[$], want_m1_q[$];
  logic [31:0] m0_log[$], m1_log[$];
  int          tags_q[$];
  int          cmd_log[$];
  int          cmd_pkts   = 0;
  int          cmd_beats  = 0;
  int          resp_beats = 0;
  int          m_beats    = 0;
  int          owner      = 0;
  bit          mid_pkt    = 1'b0;
  bit          auto_resp  = 1'b0;
  int unsigned rdy_pct    = 100;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    s0_if.tvalid   = (src0_q.size() > 0);
    s0_if.tdata    = s0_if.tvalid ? src0_q[0][31:0] : '0;
    s0_if.tlast    = s0_if.tvalid ? src0_q[0][32] : 1'b0;
    s1_if.tvalid   = (src1_q.size() > 0);
    s1_if.tdata    = s1_if.tvalid ? src1_q[0][31:0] : '0;
    s1_if.tlast    = s1_if.tvalid ? src1_q[0][32] : 1'b0;
    resp_if.tvalid = (resp_q.size() > 0);
    resp_if.tdata  = resp_if.tvalid ? resp_q[0][31:0] : '0;
    resp_if.tlast  = resp_if.tvalid ? resp_q[0][32] : 1'b0;
    cmd_if.tready  = ($urandom_range(99) < rdy_pct);
    m0_if.tready   = ($urandom_range(99) < rdy_pct);
    m1_if.tready   = ($urandom_range(99) < rdy_pct);
  endtask

  // The handler answers each completed command with 1..3 random words for its requester.
  task automatic gen_resp(input int dest);
    int unsigned n;
    logic [32:0] beat;
    n = $urandom_range(3, 1);
    for (int unsigned j = 0; j < n; j++) begin
      beat = {(j == n - 1), 32'($urandom)};
      resp_q.push_back(beat);
      resp_beats++;
      if (dest == 1) want_m1_q.push_back(beat);
      else           want_m0_q.push_back(beat);
    end
  endtask

  task automatic sample();
    bit f_s0, f_s1, f_cmd, f_resp, f_m0, f_m1;
    bit hv;
    logic [63:0] exp_beat;
    f_s0   = s0_if.tvalid && s0_if.tready;
    f_s1   = s1_if.tvalid && s1_if.tready;
    f_cmd  = cmd_if.tvalid && cmd_if.tready;
    f_resp = resp_if.tvalid && resp_if.tready;
    f_m0   = m0_if.tvalid && m0_if.tready;
    f_m1   = m1_if.tvalid && m1_if.tready;
    hv     = (tags_q.size() > 0);

    check("outstanding", outstanding, tags_q.size());
    check("m0_tvalid", m0_if.tvalid, resp_if.tvalid && hv && tags_q[0] == 0);
    check("m1_tvalid", m1_if.tvalid, resp_if.tvalid && hv && tags_q[0] == 1);
    check("resp_tready", resp_if.tready,
          hv && ((tags_q[0] == 1) ? m1_if.tready : m0_if.tready));
    check("s_tready_excl", s0_if.tready && s1_if.tready, 0);
    if (tags_q.size() == TD)
      check("full_stall", {cmd_if.tvalid, s0_if.tready, s1_if.tready}, 0);

    if (f_cmd) begin
      if (!mid_pkt) owner = cmd_if.tdata[31];
      if (owner == 1) exp_beat = (exp1_q.size() > 0) ? 64'(exp1_q.pop_front()) : NONE;
      else            exp_beat = (exp0_q.size() > 0) ? 64'(exp0_q.pop_front()) : NONE;
      check("cmd_beat", {cmd_if.tlast, cmd_if.tdata}, exp_beat);
      check("cmd_src_fire", (owner == 1) ? f_s1 : f_s0, 1);
      cmd_beats++;
      mid_pkt = !cmd_if.tlast;
      if (cmd_if.tlast) begin
        tags_q.push_back(owner);
        cmd_log.push_back(owner);
        cmd_pkts++;
        if (auto_resp) gen_resp(owner);
      end
    end

    if (f_resp) begin
      check("resp_m_fire", {f_m0, f_m1}, (hv && tags_q[0] == 1) ? 2'b01 : 2'b10);
      if (hv && resp_if.tlast) void'(tags_q.pop_front());
      void'(resp_q.pop_front());
    end
    if (f_m0) begin
      exp_beat = (want_m0_q.size() > 0) ? 64'(want_m0_q.pop_front()) : NONE;
      check("m0_beat", {m0_if.tlast, m0_if.tdata}, exp_beat);
      m0_log.push_back(m0_if.tdata);
      m_beats++;
    end
    if (f_m1) begin
      exp_beat = (want_m1_q.size() > 0) ? 64'(want_m1_q.pop_front()) : NONE;
      check("m1_beat", {m1_if.tlast, m1_if.tdata}, exp_beat);
      m1_log.push_back(m1_if.tdata);
      m_beats++;
    end
    if (f_s0) void'(src0_q.pop_front());
    if (f_s1) void'(src1_q.pop_front());
  endtask

  task automatic step();
    @(negedge inner_clk);
    sample();
    @(posedge inner_clk);
    #1;
    drive();
  endtask

  task automatic add_pkt(input int src, input int n, input logic [31:0] base);
    logic [32:0] beat;
    for (int i = 0; i < n; i++) begin
      beat = {(i == n - 1), base + 32'(i)};
      if (src == 1) begin
        src1_q.push_back(beat);
        exp1_q.push_back(beat);
      end else begin
        src0_q.push_back(beat);
        exp0_q.push_back(beat);
      end
    end
  endtask

  task automatic add_resp(input int dest, input logic [31:0] data, input bit last);
    resp_q.push_back({last, data});
    resp_beats++;
    if (dest == 1) want_m1_q.push_back({last, data});
    else           want_m0_q.push_back({last, data});
  endtask

  task automatic wait_pkts(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && cmd_pkts < n; i++) step();
    check(tag, cmd_pkts, n);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    for (int i = 0; i < budget && (want_m0_q.size() + want_m1_q.size() + resp_q.size()) > 0;
         i++)
      step();
    check(tag, want_m0_q.size() + want_m1_q.size() + resp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src0_q.delete(); src1_q.delete(); exp0_q.delete(); exp1_q.delete();
    resp_q.delete(); want_m0_q.delete(); want_m1_q.delete();
    m0_log.delete(); m1_log.delete(); tags_q.delete(); cmd_log.delete();
    cmd_pkts = 0;
    mid_pkt  = 1'b0;
    drive();
    #1;
    check("rst_hs_zero", {cmd_if.tvalid, m0_if.tvalid, m1_if.tvalid,
                          s0_if.tready, s1_if.tready, resp_if.tready}, 0);
    check("rst_outstanding", outstanding, 0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int base_beats;
    drive();
    @(posedge inner_clk);
    #1;
    do_reset();

    // Single packet, then one from s1, then in-order responses to each.
    add_pkt(0, 3, 32'h10);
    wait_pkts(1, 20, "t1_pkts");
    check("t1_out1", outstanding, 1);
    check("t1_src", cmd_log[0], 0);
    add_pkt(1, 1, 32'h8000_0020);
    wait_pkts(2, 20, "t1_pkts2");
    check("t1_out2", outstanding, 2);
    add_resp(0, 32'hA0, 1'b1);
    add_resp(1, 32'hB0, 1'b0);
    add_resp(1, 32'hB1, 1'b1);
    wait_drain(40, "t1_drain");
    check("t1_m0_n", m0_log.size(), 1);
    check("t1_m0_0", m0_log[0], 32'hA0);
    check("t1_m1_n", m1_log.size(), 2);
    check("t1_m1_0", m1_log[0], 32'hB0);
    check("t1_m1_1", m1_log[1], 32'hB1);
    check("t1_out0", outstanding, 0);

    // Contention from reset: s0 first, then strict alternation.
    do_reset();
    add_pkt(0, 2, 32'h100);
    add_pkt(1, 2, 32'h8000_0100);
    wait_pkts(2, 30, "t2_pkts");
    check("t2_first", cmd_log[0], 0);
    check("t2_second", cmd_log[1], 1);
    add_pkt(0, 1, 32'h110);
    add_pkt(1, 1, 32'h8000_0110);
    wait_pkts(4, 30, "t2_pkts2");
    check("t2_third", cmd_log[2], 0);
    check("t2_fourth", cmd_log[3], 1);

    // Full tag FIFO stalls the fifth packet until one response retires.
    do_reset();
    for (int i = 0; i < int'(TD); i++) add_pkt(0, 1, 32'h200 + 32'(i));
    wait_pkts(TD, 40, "t3_fill");
    check("t3_full_out", outstanding, TD);
    add_pkt(0, 1, 32'h2FF);
    for (int i = 0; i < 5; i++) step();
    check("t3_stall_rdy", s0_if.tready, 0);
    check("t3_stall_out", outstanding, TD);
    check("t3_stall_pkts", cmd_pkts, TD);
    add_resp(0, 32'hC0, 1'b1);
    wait_pkts(TD + 1, 8, "t3_fifth");
    check("t3_out_after", outstanding, TD);

    // Reset in the middle of a packet with two tags pending.
    do_reset();
    add_pkt(0, 1, 32'h300);
    add_pkt(1, 1, 32'h8000_0300);
    wait_pkts(2, 20, "t4_pkts");
    check("t4_out2", outstanding, 2);
    add_pkt(0, 4, 32'h310);
    base_beats = cmd_beats;
    for (int i = 0; i < 20 && (cmd_beats - base_beats) < 2; i++) step();
    check("t4_two_beats", cmd_beats - base_beats, 2);
    check("t4_mid", mid_pkt, 1);
    do_reset();
    add_pkt(1, 2, 32'h8000_0400);
    wait_pkts(1, 20, "t4_after");
    check("t4_after_src", cmd_log[0], 1);
    check("t4_after_out", outstanding, 1);

    // Random backpressure over 200 packets with an auto-responding handler.
    do_reset();
    rdy_pct    = 60;
    auto_resp  = 1'b1;
    resp_beats = 0;
    m_beats    = 0;
    for (int i = 0; i < 100; i++) begin
      n = int'($urandom_range(4, 1));
      add_pkt(0, n, 32'(i) << 8);
      n = int'($urandom_range(4, 1));
      add_pkt(1, n, 32'h8000_0000 | (32'(i) << 8));
    end
    wait_pkts(200, 20000, "rnd_pkts");
    wait_drain(5000, "rnd_drain");
    check("rnd_beats", m_beats, resp_beats);
    check("rnd_out0", outstanding, 0);
    check("rnd_tags", tags_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_cmd_arbiter.md
CTRL_CMD_ARBITER -- requirements
Module: ctrl_cmd_arbiter

Interface
REQ-001 Parameter DATA_W, 32, AXIS tdata width for all streams.
REQ-002 Parameter TAG_DEPTH, 4, max outstanding command packets awaiting response (power of 2, 2..16).
REQ-003 inner_clk  in  1  single clock; all ports synchronous to it.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 s0_tdata/s0_tvalid/s0_tlast  in  DATA_W/1/1, s0_tready  out  1: requester 0 command stream.
REQ-006 s1_tdata/s1_tvalid/s1_tlast  in  DATA_W/1/1, s1_tready  out  1: requester 1 command stream.
REQ-007 cmd_tdata/cmd_tvalid/cmd_tlast  out  DATA_W/1/1, cmd_tready  in  1: merged stream to command handler.
REQ-008 resp_tdata/resp_tvalid/resp_tlast  in  DATA_W/1/1, resp_tready  out  1: handler response stream.
REQ-009 m0_tdata/m0_tvalid/m0_tlast  out  DATA_W/1/1, m0_tready  in  1: response to requester 0.
REQ-010 m1_tdata/m1_tvalid/m1_tlast  out  DATA_W/1/1, m1_tready  in  1: response to requester 1.
REQ-011 outstanding  out  $clog2(TAG_DEPTH)+1  packets forwarded but not yet fully responded.

Function
REQ-012 Command arbiter FSM states: IDLE, FWD; grant register gnt (0/1), last-winner register lw.
REQ-013 IDLE: if outstanding < TAG_DEPTH and any sN_tvalid, grant requester != lw when both valid, else the valid one; go FWD next cycle; no data transfer in IDLE.
REQ-014 FWD: cmd_tdata/tvalid/tlast = granted s-stream combinationally; granted sN_tready = cmd_tready; ungranted sN_tready = 0.
REQ-015 FWD: on cmd_tvalid & cmd_tready & cmd_tlast, push gnt into tag FIFO, lw <= gnt, return to IDLE (one bubble cycle per packet).
REQ-016 Arbitration is packet-granular; no switch mid-packet regardless of other requester's valid.
REQ-017 IDLE: cmd_tvalid = 0, s0_tready = s1_tready = 0.
REQ-018 Tag FIFO full (outstanding == TAG_DEPTH): FSM holds IDLE; valid requesters stall.
REQ-019 Response router: tag FIFO empty -> resp_tready = 0, m0_tvalid = m1_tvalid = 0.
REQ-020 Tag FIFO non-empty, head = h: m{h} data/valid/last = resp stream; resp_tready = m{h}_tready; other m-stream tvalid = 0.
REQ-021 On resp_tvalid & resp_tready & resp_tlast, pop tag FIFO; next beat routed by new head.
REQ-022 Simultaneous push and pop in one cycle: outstanding unchanged, both take effect.
REQ-023 Response words with tag FIFO empty are not accepted (held by handler).
REQ-024 outstanding = tag FIFO occupancy, registered, updated same edge as push/pop.
REQ-025 No data modification; mN_tdata equals resp_tdata bit-for-bit.

Reset
REQ-026 On rst: FSM = IDLE, gnt = 0, lw = 1 (requester 0 wins first contest), tag FIFO empty, outstanding = 0.
REQ-027 During/after rst all tvalid and tready outputs = 0 until first post-reset edge logic applies.
REQ-028 rst mid-packet aborts silently; partial packets and pending tags discarded, no recovery beats.

Structure
REQ-029 Package ctrl_arb_pkg holds DATA_W default, TAG_DEPTH default, arb_state_t enum {IDLE, FWD}.
REQ-030 Sub-module ctrl_tag_fifo: 1-bit-wide synchronous FIFO, depth TAG_DEPTH, push/pop/full/empty/count, show-ahead head.

Verification
REQ-031 s0 sends 3-beat packet 0x10,0x11,0x12, s1 idle -> cmd sees same 3 beats, tlast on 0x12, outstanding 0->1.
REQ-032 s0 and s1 both valid from reset -> s0 packet forwarded first, then s1; repeat both -> s0,s1 alternate.
REQ-033 Handler returns 2 responses (0xA0; 0xB0,0xB1) after s0 then s1 commands -> 0xA0 on m0 only, 0xB0,0xB1 on m1 only.
REQ-034 TAG_DEPTH=4, 5 single-beat commands, no responses -> 5th stalls (s*_tready=0, outstanding=4); one response accepted -> 5th forwarded same-or-next cycle.
REQ-035 Random cmd_tready/m*_tready backpressure, 200 packets -> every response on correct requester, order preserved, no beat lost.
REQ-036 rst asserted in mid-FWD of 4-beat packet with outstanding=2 -> next cycle all valid/ready 0, outstanding=0, new packet from s1 forwarded normally.
